// File: rtl/jtag_dmi_host.sv
// jtag_dmi_host: JTAG-side DMI initiator driving a RISC-V DTM TAP.
// Request/response ports are flattened vectors:
//   dmi_req_i  = {addr[AbitsWidth-1:0], data[31:0], op[1:0]}  (op: 1 read, 2 write)
//   dmi_resp_o = {data[31:0], resp[1:0]}                      (resp: 0 ok, 2 failed, 3 busy)
// Optional feature macro: JTAG_DMI_HOST_TRST_EN (drive trst_no low for 8 TCK after reset).
// Every JTAG sequence starts with TMS=1/TDI=0, so the last falling edge of one
// sequence already presents the first bit of whatever sequence comes next.
module jtag_dmi_host #(
  parameter int ClkDiv     = 2,
  parameter int IdleCycles = 1,
  parameter int IrLength   = 5,
  parameter int AbitsWidth = 7
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AbitsWidth+33:0]  dmi_req_i,
  input  logic                    dmi_req_valid_i,
  output logic                    dmi_req_ready_o,
  output logic [33:0]             dmi_resp_o,
  output logic                    dmi_resp_valid_o,
  input  logic                    dmi_resp_ready_i,
  output logic                    tck_o,
  output logic                    tms_o,
  output logic                    tdi_o,
  input  logic                    tdo_i,
  output logic                    trst_no
);

  localparam int DrLen = AbitsWidth + 34;

  localparam logic [1:0]  OpWrite      = 2'd2;
  localparam logic [1:0]  StBusy       = 2'd3;
  localparam logic [15:0] DivM1        = 16'(ClkDiv - 1);
  localparam logic [15:0] TrstLen      = 16'd8;
  localparam logic [15:0] TapRstLen    = 16'd6;
  localparam logic [15:0] IrShEnd      = 16'(4 + IrLength);
  localparam logic [15:0] IrScanLen    = 16'(IrLength + 6);
  localparam logic [15:0] DmiDl        = 16'(DrLen);
  localparam logic [15:0] DtmcsDl      = 16'd32;
  localparam logic [15:0] DmiScanLen   = 16'(DrLen + 4 + IdleCycles);
  localparam logic [15:0] DtmcsScanLen = 16'(32 + 4 + IdleCycles);
  localparam logic [15:0] CapFirst     = 16'd3;
  localparam logic [15:0] CapEnd       = 16'd37;

  localparam logic [IrLength-1:0] IrDmi      = IrLength'(5'h11);
  localparam logic [IrLength-1:0] IrDtmcs    = IrLength'(5'h10);
  localparam logic [DrLen-1:0]    DtmcsReset = DrLen'(32'h0001_0000);

  typedef enum logic [2:0] {
    S_IDLE, S_TRST, S_TAPRST, S_IRSCAN, S_DRREQ, S_DRNOP, S_CLRERR, S_RESPOND
  } state_e;

`ifdef JTAG_DMI_HOST_TRST_EN
  localparam state_e ResetState = S_TRST;
  localparam logic   TrstReset  = 1'b0;
`else
  localparam state_e ResetState = S_IDLE;
  localparam logic   TrstReset  = 1'b1;
`endif

  // {tms, tdi} for TCK index i of the sequence belonging to state st.
  function automatic logic [1:0] seq_bit(input state_e st, input logic [15:0] i,
                                         input logic [IrLength-1:0] ir,
                                         input logic [DrLen-1:0] dv,
                                         input logic [15:0] dl);
    logic [1:0]          r;
    logic [DrLen-1:0]    dsh;
    logic [IrLength-1:0] ish;
    r   = 2'b00;
    dsh = dv >> (i - 16'd3);
    ish = ir >> (i - 16'd4);
    case (st)
      S_TRST:   r = 2'b10;
      S_TAPRST: r = (i < 16'd5) ? 2'b10 : 2'b00;
      S_IRSCAN: begin
        if (i < 16'd2)                r = 2'b10;
        else if (i < 16'd4)           r = 2'b00;
        else if (i < IrShEnd)         r = {(i == IrShEnd - 16'd1), ish[0]};
        else if (i == IrShEnd)        r = 2'b10;
        else                          r = 2'b00;
      end
      S_DRREQ, S_DRNOP, S_CLRERR: begin
        if (i == 16'd0)               r = 2'b10;
        else if (i < 16'd3)           r = 2'b00;
        else if (i < dl + 16'd3)      r = {(i == dl + 16'd2), dsh[0]};
        else if (i == dl + 16'd3)     r = 2'b10;
        else                          r = 2'b00;
      end
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         bit_q, bit_d;
  logic                tck_q, tck_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                trst_q, trst_d;
  logic                ir_loaded_q, ir_loaded_d;
  logic [IrLength-1:0] ir_val_q, ir_val_d;
  logic                clr_q, clr_d;
  logic [DrLen-1:0]    req_q, req_d;
  logic [33:0]         cap_q, cap_d;
  logic [33:0]         resp_q, resp_d;
  logic                resp_valid_q, resp_valid_d;
  logic                req_ready_q, req_ready_d;

  logic                active_s, tick_s, rise_s, fall_s;
  logic [15:0]         seq_len_s, dl_s;
  logic [DrLen-1:0]    dr_vec_s;
  logic [1:0]          nxt_s;

  // Per-state sequence geometry: total TCK count, DR length and DR contents.
  always_comb begin
    seq_len_s = TapRstLen;
    dl_s      = DmiDl;
    dr_vec_s  = req_q;
    case (state_q)
      S_TRST:   seq_len_s = TrstLen;
      S_TAPRST: seq_len_s = TapRstLen;
      S_IRSCAN: seq_len_s = IrScanLen;
      S_DRREQ:  seq_len_s = DmiScanLen;
      S_DRNOP: begin
        seq_len_s = DmiScanLen;
        dr_vec_s  = {req_q[DrLen-1:2], 2'b00};
      end
      S_CLRERR: begin
        seq_len_s = DtmcsScanLen;
        dl_s      = DtmcsDl;
        dr_vec_s  = DtmcsReset;
      end
      default: seq_len_s = TapRstLen;
    endcase
  end

  assign active_s = (state_q != S_IDLE) && (state_q != S_RESPOND);
  assign tick_s   = active_s && (cnt_q == DivM1);
  assign rise_s   = tick_s && !tck_q;
  assign fall_s   = tick_s && tck_q;
  assign nxt_s    = seq_bit(state_q, bit_q + 16'd1, ir_val_q, dr_vec_s, dl_s);

  // TCK divider, sequence stepping, TDO capture, FSM transitions and handshakes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = 16'd0;
    bit_d        = bit_q;
    tck_d        = 1'b0;
    tms_d        = tms_q;
    tdi_d        = tdi_q;
    trst_d       = trst_q;
    ir_loaded_d  = ir_loaded_q;
    ir_val_d     = ir_val_q;
    clr_d        = clr_q;
    req_d        = req_q;
    cap_d        = cap_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;

    if (active_s) begin
      if (tick_s) begin
        cnt_d = 16'd0;
        tck_d = ~tck_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
        tck_d = tck_q;
      end
    end else begin
      cnt_d = 16'd0;
      tck_d = 1'b0;
    end

    // The first 34 shifted-out bits are {data, status}, LSB first.
    if (rise_s && (state_q == S_DRNOP) && (bit_q >= CapFirst) && (bit_q < CapEnd)) begin
      cap_d = {tdo_i, cap_q[33:1]};
    end else begin
      cap_d = cap_q;
    end

    if (fall_s) begin
      if (bit_q == seq_len_s - 16'd1) begin
        bit_d = 16'd0;
        tms_d = 1'b1;
        tdi_d = 1'b0;
        case (state_q)
          S_TRST: begin
            trst_d  = 1'b1;
            state_d = S_IDLE;
          end
          S_TAPRST: begin
            ir_val_d = IrDmi;
            state_d  = S_IRSCAN;
          end
          S_IRSCAN: begin
            if (ir_val_q == IrDmi) begin
              ir_loaded_d = 1'b1;
              if (clr_q) begin
                clr_d        = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = S_RESPOND;
              end else begin
                state_d = S_DRREQ;
              end
            end else begin
              state_d = S_CLRERR;
            end
          end
          S_DRREQ: state_d = S_DRNOP;
          S_DRNOP: begin
            resp_d[1:0]  = cap_q[1:0];
            resp_d[33:2] = (req_q[1:0] == OpWrite) ? 32'h0000_0000 : cap_q[33:2];
            if (cap_q[1:0] == StBusy) begin
              ir_loaded_d = 1'b0;
              ir_val_d    = IrDtmcs;
              clr_d       = 1'b1;
              state_d     = S_IRSCAN;
            end else begin
              resp_valid_d = 1'b1;
              state_d      = S_RESPOND;
            end
          end
          S_CLRERR: begin
            ir_val_d = IrDmi;
            state_d  = S_IRSCAN;
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        bit_d = bit_q + 16'd1;
        tms_d = nxt_s[1];
        tdi_d = nxt_s[0];
      end
    end else begin
      bit_d = bit_q;
    end

    case (state_q)
      S_IDLE: begin
        if (dmi_req_valid_i && req_ready_q) begin
          req_d   = dmi_req_i;
          state_d = ir_loaded_q ? S_DRREQ : S_TAPRST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESPOND: begin
        if (dmi_resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        resp_valid_d = resp_valid_d;
      end
    endcase

    req_ready_d = (state_d == S_IDLE) && !resp_valid_d;
  end

  // State and output registers; reset parks the JTAG pins and drops any transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ResetState;
      cnt_q        <= 16'd0;
      bit_q        <= 16'd0;
      tck_q        <= 1'b0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b0;
      trst_q       <= TrstReset;
      ir_loaded_q  <= 1'b0;
      ir_val_q     <= IrDmi;
      clr_q        <= 1'b0;
      req_q        <= '0;
      cap_q        <= 34'd0;
      resp_q       <= 34'd0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      tck_q        <= tck_d;
      tms_q        <= tms_d;
      tdi_q        <= tdi_d;
      trst_q       <= trst_d;
      ir_loaded_q  <= ir_loaded_d;
      ir_val_q     <= ir_val_d;
      clr_q        <= clr_d;
      req_q        <= req_d;
      cap_q        <= cap_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign tck_o            = tck_q;
  assign tms_o            = tms_q;
  assign tdi_o            = tdi_q;
  assign trst_no          = trst_q;
  assign dmi_req_ready_o  = req_ready_q;
  assign dmi_resp_o       = resp_q;
  assign dmi_resp_valid_o = resp_valid_q;

endmodule

// File: tb/tb_jtag_dmi_host.sv
// Bench for jtag_dmi_host: drives DMI requests against a behavioural DTM TAP
// model and checks responses through an expected-response queue.
module tb_jtag_dmi_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [40:0] dmi_req = 41'd0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [33:0] resp;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        tck, tms, tdi, trst;
  logic        tdo = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

`ifdef JTAG_DMI_HOST_TRST_EN
  localparam logic ExpTrstRst = 1'b0;
`else
  localparam logic ExpTrstRst = 1'b1;
`endif

  always #5 clk = ~clk;

  jtag_dmi_host dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dmi_req_i(dmi_req), .dmi_req_valid_i(req_valid), .dmi_req_ready_o(req_ready),
    .dmi_resp_o(resp), .dmi_resp_valid_o(resp_valid), .dmi_resp_ready_i(resp_ready),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .trst_no(trst)
  );

  // ---------------- DTM TAP model ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PDR;
      PDR:   return m ? EX2DR : PDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PIR;
      PIR:   return m ? EX2IR : PIR;
      EX2IR: return m ? UPIR  : SHIR;
      UPIR:  return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  tap_e        tap = TLR;
  logic [4:0]  ir = 5'h01, ir_sh = 5'h01;
  logic [40:0] dmi_sh = 41'd0;
  logic [31:0] dtm_sh = 32'd0;
  logic        byp = 1'b0;
  int          sh_cnt = 0;
  logic [1:0]  sticky = 2'd0;
  logic [6:0]  dmi_addr_r = 7'd0;
  logic [31:0] dmi_data_r = 32'd0;
  logic        inject_busy = 1'b0;
  logic [31:0] mem [0:127];
  logic [4:0]  ir_log [$];
  logic [40:0] dmi_log [$];
  logic [31:0] dtm_log [$];

  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap = TLR;
      ir  = 5'h01;
    end else begin
      case (tap)
        TLR: ir = 5'h01;
        CAPDR: begin
          sh_cnt = 0;
          dmi_sh = {dmi_addr_r, dmi_data_r, sticky};
          dtm_sh = {20'd0, sticky, 10'h071};
        end
        SHDR: begin
          sh_cnt++;
          if (ir == 5'h11)      dmi_sh = {tdi, dmi_sh[40:1]};
          else if (ir == 5'h10) dtm_sh = {tdi, dtm_sh[31:1]};
          else                  byp = tdi;
        end
        UPDR: begin
          if (ir == 5'h11) begin
            dmi_log.push_back(dmi_sh);
            if (dmi_sh[1:0] != 2'd0 && sticky == 2'd0) begin
              if (inject_busy) begin
                sticky = 2'd3;
                inject_busy = 1'b0;
              end else begin
                dmi_addr_r = dmi_sh[40:34];
                dmi_data_r = mem[dmi_sh[40:34]];
                if (dmi_sh[1:0] == 2'd2) mem[dmi_sh[40:34]] = dmi_sh[33:2];
              end
            end
          end else if (ir == 5'h10) begin
            dtm_log.push_back(dtm_sh);
            if (dtm_sh[16]) sticky = 2'd0;
          end
        end
        CAPIR: ir_sh = 5'b00001;
        SHIR:  ir_sh = {tdi, ir_sh[4:1]};
        UPIR: begin
          ir = ir_sh;
          ir_log.push_back(ir_sh);
        end
        default: ;
      endcase
      tap = tap_next(tap, tms);
    end
  end

  always @(negedge tck) begin
    if (tap == SHDR)      tdo = (ir == 5'h11) ? dmi_sh[0] : ((ir == 5'h10) ? dtm_sh[0] : byp);
    else if (tap == SHIR) tdo = ir_sh[0];
    else                  tdo = 1'b0;
  end

  // ---------------- TCK / TMS observation ----------------
  int        rises = 0;
  int        txn_start = 0;
  logic [7:0] tms_hist = 8'd0;
  always @(posedge tck) begin
    if (rises - txn_start < 8) tms_hist[rises - txn_start] = tms;
    rises++;
  end

  logic abort_win = 1'b0;
  int   spurious = 0;
  always @(posedge clk) if (abort_win && resp_valid) spurious++;

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                      input logic [33:0] expr);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 2000) begin @(negedge clk); t++; end
    chk("req_ready_before_send", req_ready, 1'b1);
    dmi_req   = {a, d, op};
    req_valid = 1'b1;
    txn_start = rises;
    tms_hist  = 8'd0;
    exp_q.push_back(expr);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int hold);
    int t;
    logic [33:0] snap;
    logic [33:0] e;
    t = 0;
    while (!resp_valid && t < 5000) begin @(negedge clk); t++; end
    chk("resp_valid_rise", resp_valid, 1'b1);
    snap = resp;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_resp_stable", resp, snap);
      chk("hold_req_ready_low", req_ready, 1'b0);
    end
    chk("scoreboard_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("resp", resp, e);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 1'b0);
  endtask

  int n_ir, n_dmi, n_dtm, t;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[7'h10] = 32'hCAFE_0000;
    mem[7'h11] = 32'h1122_3344;
    mem[7'h04] = 32'hDEAD_BEEF;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tck", tck, 1'b0);
    chk("rst_tms", tms, 1'b1);
    chk("rst_tdi", tdi, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp", resp, 34'd0);
    chk("rst_trst", trst, ExpTrstRst);
    rst_n = 1'b1;

    // 1: first read after reset -> TAP reset, IR scan 0x11, two DMI scans
    n_ir = ir_log.size(); n_dmi = dmi_log.size();
    send(7'h11, 32'h0, 2'd1, {32'h1122_3344, 2'd0});
    wait_resp(0);
    chk("t1_tck_count", 64'(rises - txn_start), 64'd109);
    chk("t1_tapreset_tms", tms_hist[5:0], 6'b011111);
    chk("t1_ir_scans", 64'(ir_log.size() - n_ir), 64'd1);
    chk("t1_ir_value", ir_log[n_ir], 5'h11);
    chk("t1_dmi_scans", 64'(dmi_log.size() - n_dmi), 64'd2);
    chk("t1_trst_released", trst, 1'b1);

    // 2: write 0x10 <- 1, host must report data 0
    n_dmi = dmi_log.size();
    send(7'h10, 32'h0000_0001, 2'd2, {32'h0, 2'd0});
    wait_resp(0);
    chk("t2_req_dr", dmi_log[n_dmi], {7'h10, 32'h1, 2'd2});
    chk("t2_nop_dr", dmi_log[n_dmi + 1], {7'h10, 32'h1, 2'd0});
    chk("t2_mem", mem[7'h10], 32'h1);
    chk("t2_tck_count", 64'(rises - txn_start), 64'd92);

    // 3: read 0x04
    send(7'h04, 32'h0, 2'd1, {32'hDEAD_BEEF, 2'd0});
    wait_resp(0);
    chk("t3_tck_count", 64'(rises - txn_start), 64'd92);

    // 4: busy on a write; also hold the response for 10 cycles
    n_ir = ir_log.size(); n_dtm = dtm_log.size();
    inject_busy = 1'b1;
    send(7'h05, 32'h0000_0055, 2'd2, {32'h0, 2'd3});
    t = 0;
    while (!resp_valid && t < 5000) begin @(negedge clk); t++; end
    chk("t4_ir_scans", 64'(ir_log.size() - n_ir), 64'd2);
    chk("t4_ir_first", ir_log[n_ir], 5'h10);
    chk("t4_ir_second", ir_log[n_ir + 1], 5'h11);
    chk("t4_dtmcs_scans", 64'(dtm_log.size() - n_dtm), 64'd1);
    chk("t4_dtmcs_value", dtm_log[n_dtm], 32'h0001_0000);
    chk("t4_sticky_cleared", sticky, 2'd0);
    chk("t4_mem_untouched", mem[7'h05], 32'h1000_0005);
    wait_resp(10);

    // 5: read after busy recovery goes straight to DR scans
    send(7'h11, 32'h0, 2'd1, {32'h1122_3344, 2'd0});
    wait_resp(0);
    chk("t5_tck_count", 64'(rises - txn_start), 64'd92);

    // 6: reset during DR shift bit 20
    send(7'h04, 32'h0, 2'd1, {32'hDEAD_BEEF, 2'd0});
    t = 0;
    while (!(tap == SHDR && sh_cnt == 20) && t < 5000) begin @(negedge clk); t++; end
    chk("t6_reached_shift20", 64'(sh_cnt), 64'd20);
    rst_n = 1'b0;
    abort_win = 1'b1;
    #1;
    chk("t6_rst_tck", tck, 1'b0);
    chk("t6_rst_tms", tms, 1'b1);
    chk("t6_rst_resp_valid", resp_valid, 1'b0);
    chk("t6_rst_trst", trst, ExpTrstRst);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (200) @(negedge clk);
    abort_win = 1'b0;
    chk("t6_no_response", 64'(spurious), 64'd0);

    // 7: next request restarts with TAP reset
    n_ir = ir_log.size();
    send(7'h04, 32'h0, 2'd1, {32'hDEAD_BEEF, 2'd0});
    wait_resp(0);
    chk("t7_tck_count", 64'(rises - txn_start), 64'd109);
    chk("t7_tapreset_tms", tms_hist[5:0], 6'b011111);
    chk("t7_ir_value", ir_log[n_ir], 5'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
